// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: owns the register file and
// drives the ID/EX pipeline register feeding execute.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regwriteW,
    input  logic [4:0]  rdW,
    input  logic [31:0] resultW,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic [31:0] pc4D,
    output logic        regwriteE,
    output logic        memrwE,
    output logic        aselE,
    output logic        bselE,
    output logic [1:0]  wbselE,
    output logic [2:0]  ALUselE,
    output logic [4:0]  rdE,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] imm_exE,
    output logic [31:0] pcE,
    output logic [31:0] pc4E
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_t;

    logic [31:0] rf [0:31];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wr_en;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic        is_r;
    logic        is_i;
    logic        is_ld;
    logic        is_st;
    logic        is_jal;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_j;

    logic        alu_ok;
    alu_t        alu_op;

    logic        regwrite;
    logic        memrw;
    logic        asel;
    logic        bsel;
    logic [1:0]  wbsel;
    logic [2:0]  alusel;
    logic [31:0] imm;

    assign opcode = instrD[6:0];
    assign rd     = instrD[11:7];
    assign funct3 = instrD[14:12];
    assign rs1    = instrD[19:15];
    assign rs2    = instrD[24:20];
    assign alt    = instrD[30];

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LD);
    assign is_st  = (opcode == OP_ST);
    assign is_jal = (opcode == OP_JAL);

    assign imm_i = {{20{instrD[31]}}, instrD[31:20]};
    assign imm_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
    assign imm_j = {{12{instrD[31]}}, instrD[19:12], instrD[20],
                    instrD[30:21], 1'b0};

    // x0 is never written, so its storage slot stays unused
    assign wr_en = regwriteW && (rdW != 5'd0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rf[rdW] <= resultW;
        end
    end

    assign rd1 = (rs1 == 5'd0) ? 32'd0 :
                 (wr_en && rdW == rs1) ? resultW : rf[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 :
                 (wr_en && rdW == rs2) ? resultW : rf[rs2];

    // SLTU and arithmetic right shifts have no ALU code
    always_comb begin
        alu_ok = 1'b1;
        alu_op = ALU_ADD;
        unique case (funct3)
            3'b000: alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_ok = 1'b0;
            3'b100: alu_op = ALU_XOR;
            3'b101: begin
                alu_op = ALU_SRL;
                alu_ok = !alt;
            end
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        regwrite = 1'b0;
        memrw    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        wbsel    = 2'b00;
        alusel   = ALU_ADD;
        imm      = 32'd0;
        unique case (1'b1)
            is_r && alu_ok: begin
                regwrite = 1'b1;
                wbsel    = 2'b01;
                alusel   = alu_op;
            end
            is_i && alu_ok: begin
                regwrite = 1'b1;
                bsel     = 1'b1;
                wbsel    = 2'b01;
                alusel   = alu_op;
                imm      = imm_i;
            end
            is_ld: begin
                regwrite = 1'b1;
                bsel     = 1'b1;
                imm      = imm_i;
            end
            is_st: begin
                memrw = 1'b1;
                bsel  = 1'b1;
                imm   = imm_s;
            end
            is_jal: begin
                regwrite = 1'b1;
                asel     = 1'b1;
                bsel     = 1'b1;
                wbsel    = 2'b10;
                imm      = imm_j;
            end
            default: begin
                regwrite = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            regwriteE <= 1'b0;
            memrwE    <= 1'b0;
            aselE     <= 1'b0;
            bselE     <= 1'b0;
            wbselE    <= 2'b00;
            ALUselE   <= 3'b000;
            rdE       <= 5'd0;
            rs1E      <= 5'd0;
            rs2E      <= 5'd0;
            rd1E      <= 32'd0;
            rd2E      <= 32'd0;
            imm_exE   <= 32'd0;
            pcE       <= 32'd0;
            pc4E      <= 32'd0;
        end else begin
            regwriteE <= regwrite;
            memrwE    <= memrw;
            aselE     <= asel;
            bselE     <= bsel;
            wbselE    <= wbsel;
            ALUselE   <= alusel;
            rdE       <= rd;
            rs1E      <= rs1;
            rs2E      <= rs2;
            rd1E      <= rd1;
            rd2E      <= rd2;
            imm_exE   <= imm;
            pcE       <= pcD;
            pc4E      <= pc4D;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus
// randomized instructions against a behavioural decode model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc4D;
    logic        regwriteE;
    logic        memrwE;
    logic        aselE;
    logic        bselE;
    logic [1:0]  wbselE;
    logic [2:0]  ALUselE;
    logic [4:0]  rdE;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] imm_exE;
    logic [31:0] pcE;
    logic [31:0] pc4E;

    int total = 0;
    int bad = 0;

    logic [31:0]  m_rf [32];
    logic [183:0] expv;
    logic [183:0] gotv;

    // ALU code per funct3 for the non-SUB cases
    localparam logic [2:0] ALU_TAB [8] =
        '{3'd0, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd3, 3'd2};

    decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regwriteW (regwriteW),
        .rdW       (rdW),
        .resultW   (resultW),
        .instrD    (instrD),
        .pcD       (pcD),
        .pc4D      (pc4D),
        .regwriteE (regwriteE),
        .memrwE    (memrwE),
        .aselE     (aselE),
        .bselE     (bselE),
        .wbselE    (wbselE),
        .ALUselE   (ALUselE),
        .rdE       (rdE),
        .rs1E      (rs1E),
        .rs2E      (rs2E),
        .rd1E      (rd1E),
        .rd2E      (rd2E),
        .imm_exE   (imm_exE),
        .pcE       (pcE),
        .pc4E      (pc4E)
    );

    always #5 clk = ~clk;

    function automatic logic [183:0] dut_vec();
        return {regwriteE, memrwE, aselE, bselE, wbselE, ALUselE,
                rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE, pc4E};
    endfunction

    function automatic logic [31:0] m_read(
        input logic [4:0] a, input logic we,
        input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic logic [183:0] model(
        input logic r, input logic [31:0] ins,
        input logic [31:0] pc, input logic [31:0] pc4,
        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [6:0] op;
        int f3;
        logic alt;
        logic ok;
        logic rw, mw, a, b;
        logic [1:0] wb;
        logic [2:0] alu;
        int imm;
        op = ins[6:0];
        f3 = int'(ins[14:12]);
        alt = ins[30];
        rw = 0; mw = 0; a = 0; b = 0; wb = 0; alu = 0; imm = 0;
        if (r) return '0;
        ok = (f3 != 3) && !(f3 == 5 && alt);
        case (op)
            7'h33: if (ok) begin
                rw = 1; wb = 2'd1;
                alu = (f3 == 0 && alt) ? 3'd1 : ALU_TAB[f3];
            end
            7'h13: if (ok) begin
                rw = 1; b = 1; wb = 2'd1; alu = ALU_TAB[f3];
                imm = int'($signed(ins[31:20]));
            end
            7'h03: begin
                rw = 1; b = 1;
                imm = int'($signed(ins[31:20]));
            end
            7'h23: begin
                mw = 1; b = 1;
                imm = int'($signed({ins[31:25], ins[11:7]}));
            end
            7'h6f: begin
                rw = 1; a = 1; b = 1; wb = 2'd2;
                imm = int'($signed({ins[31], ins[19:12], ins[20],
                                    ins[30:21], 1'b0}));
            end
            default: ;
        endcase
        return {rw, mw, a, b, wb, alu,
                ins[11:7], ins[19:15], ins[24:20],
                m_read(ins[19:15], we, wa, wd),
                m_read(ins[24:20], we, wa, wd),
                32'(imm), pc, pc4};
    endfunction

    task automatic cyc(
        input logic r, input logic [31:0] ins,
        input logic [31:0] pc, input logic [31:0] pc4,
        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        rst_n = r; instrD = ins; pcD = pc; pc4D = pc4;
        regwriteW = we; rdW = wa; resultW = wd;
        expv = model(r, ins, pc, pc4, we, wa, wd);
        @(posedge clk);
        if (we && wa != 5'd0) m_rf[wa] = wd;
        #1;
        gotv = dut_vec();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [2:0] f3;
        logic [11:0] imm;
        logic alt;
        logic [6:0] op;
        r = $urandom;
        f3 = r[14:12];
        case ($urandom_range(0, 5))
            0: begin
                alt = (f3 == 3'd0 || f3 == 3'd5) ? r[30] : 1'b0;
                return {1'b0, alt, 5'd0, r[24:7], 7'h33};
            end
            1: begin
                imm = r[31:20];
                if (f3 == 3'd1) imm[11:5] = 7'd0;
                if (f3 == 3'd5) imm[11:5] = {1'b0, r[30], 5'd0};
                return {imm, r[19:7], 7'h13};
            end
            2: return {r[31:15], 3'b010, r[11:7], 7'h03};
            3: return {r[31:15], 3'b010, r[11:7], 7'h23};
            4: return {r[31:7], 7'h6f};
            default: begin
                op = r[6:0];
                if (op == 7'h33 || op == 7'h13 || op == 7'h03 ||
                    op == 7'h23 || op == 7'h6f) op = 7'h37;
                return {r[31:7], op};
            end
        endcase
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1, 32'h00A00093, 32'h100, 32'h104, 0, 0, 0);
            total++;
            if (gotv !== '0) begin
                bad++;
                $display("FAIL reset got=%h want=0", gotv);
            end
        end
    endtask

    task automatic test_init();
        for (int i = 1; i < 32; i++) begin
            cyc(1, 32'h00A00093, 32'h100, 32'h104, 1, 5'(i), $urandom);
            total++;
            if (gotv !== '0) begin
                bad++;
                $display("FAIL init_rst reg=%0d got=%h want=0", i, gotv);
            end
        end
    endtask

    task automatic test_release();
        logic [52:0] got;
        logic [52:0] want;
        cyc(0, 32'h00A00093, 32'h100, 32'h104, 0, 0, 0);
        got = {regwriteE, bselE, aselE, wbselE, ALUselE, rdE, rs1E,
               imm_exE};
        want = {1'b1, 1'b1, 1'b0, 2'b01, 3'd0, 5'd1, 5'd0, 32'd10};
        total++;
        if (got !== want || rd1E !== 32'd0) begin
            bad++;
            $display("FAIL release got=%h rd1=%h want=%h rd1=0",
                     got, rd1E, want);
        end
        total++;
        if (gotv !== expv) begin
            bad++;
            $display("FAIL release_vec got=%h want=%h", gotv, expv);
        end
    endtask

    task automatic test_bypass();
        logic [72:0] got;
        cyc(0, 32'h00108133, 32'h104, 32'h108, 1, 5'd1, 32'd10);
        got = {rd1E, rd2E, rdE, bselE, ALUselE};
        total++;
        if (got !== {32'd10, 32'd10, 5'd2, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL bypass got=%h want rd1=rd2=10 rd=2", got);
        end
        cyc(0, 32'h00108133, 32'h108, 32'h10C, 0, 5'd1, 32'd99);
        total++;
        if (rd1E !== 32'd10 || rd2E !== 32'd10) begin
            bad++;
            $display("FAIL rf_read got=%h/%h want=a/a", rd1E, rd2E);
        end
    endtask

    task automatic test_load_store();
        cyc(0, 32'h0000A183, 32'h10, 32'h14, 0, 0, 0);
        total++;
        if ({wbselE, memrwE, regwriteE, imm_exE} !==
            {2'b00, 1'b0, 1'b1, 32'd0}) begin
            bad++;
            $display("FAIL load got=%b %b %b %h", wbselE, memrwE,
                     regwriteE, imm_exE);
        end
        cyc(0, 32'h0030A0A3, 32'h14, 32'h18, 0, 0, 0);
        total++;
        if ({memrwE, regwriteE, imm_exE, rs2E} !==
            {1'b1, 1'b0, 32'd1, 5'd3}) begin
            bad++;
            $display("FAIL store got=%b %b %h %0d want=1 0 1 3",
                     memrwE, regwriteE, imm_exE, rs2E);
        end
        cyc(0, 32'hFE00AE23, 32'h18, 32'h1C, 0, 0, 0);
        total++;
        if (imm_exE !== 32'hFFFFFFFC) begin
            bad++;
            $display("FAIL store_neg got=%h want=fffffffc", imm_exE);
        end
        total++;
        if (gotv !== expv) begin
            bad++;
            $display("FAIL store_vec got=%h want=%h", gotv, expv);
        end
    endtask

    task automatic test_jal();
        cyc(0, 32'h010000EF, 32'h40, 32'h44, 0, 0, 0);
        total++;
        if ({aselE, bselE, wbselE, imm_exE, pcE, pc4E} !==
            {1'b1, 1'b1, 2'b10, 32'd16, 32'h40, 32'h44}) begin
            bad++;
            $display("FAIL jal got=%b %b %b %h %h %h", aselE, bselE,
                     wbselE, imm_exE, pcE, pc4E);
        end
        cyc(0, 32'hFFFFF0EF, 32'h80, 32'h84, 0, 0, 0);
        total++;
        if (imm_exE !== 32'hFFFFFFFE) begin
            bad++;
            $display("FAIL jal_neg got=%h want=fffffffe", imm_exE);
        end
    endtask

    task automatic test_x0();
        cyc(0, 32'h00000133, 32'h0, 32'h4, 1, 5'd0, 32'hDEADBEEF);
        total++;
        if (rd1E !== 32'd0 || rd2E !== 32'd0) begin
            bad++;
            $display("FAIL x0_bypass got=%h/%h want=0", rd1E, rd2E);
        end
        cyc(0, 32'h00000133, 32'h4, 32'h8, 0, 5'd0, 32'd0);
        total++;
        if (rd1E !== 32'd0) begin
            bad++;
            $display("FAIL x0_read got=%h want=0", rd1E);
        end
        cyc(0, 32'h00000013, 32'h8, 32'hC, 1, 5'd5, 32'hDEADBEEF);
        cyc(0, 32'h40528333, 32'hC, 32'h10, 0, 5'd0, 32'd0);
        total++;
        if ({ALUselE, rd1E, rd2E} !==
            {3'd1, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL sub got=%0d %h %h want=1 deadbeef",
                     ALUselE, rd1E, rd2E);
        end
    endtask

    task automatic test_nop();
        cyc(0, 32'h00000000, 32'h20, 32'h24, 0, 0, 0);
        total++;
        if ({regwriteE, memrwE, aselE, bselE, wbselE, ALUselE,
             imm_exE} !== '0) begin
            bad++;
            $display("FAIL nop_ctl got=%b%b%b%b %b %b %h", regwriteE,
                     memrwE, aselE, bselE, wbselE, ALUselE, imm_exE);
        end
        total++;
        if (gotv !== expv) begin
            bad++;
            $display("FAIL nop_vec got=%h want=%h", gotv, expv);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 32'h40528333, 32'h60, 32'h64, 0, 0, 0);
        cyc(1, 32'h40528333, 32'h64, 32'h68, 1, 5'd7, 32'h12345678);
        total++;
        if (gotv !== '0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0", gotv);
        end
        cyc(0, 32'h007283B3, 32'h68, 32'h6C, 0, 0, 0);
        total++;
        if (rd1E !== 32'hDEADBEEF || rd2E !== 32'h12345678) begin
            bad++;
            $display("FAIL rf_keep got=%h/%h want=deadbeef/12345678",
                     rd1E, rd2E);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic [31:0] pc;
        logic [4:0] wa;
        logic r;
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            ins = gen_instr();
            wa = ($urandom_range(0, 1) == 1) ? ins[19:15] : 5'($urandom);
            if ($urandom_range(0, 3) == 0) wa = ins[24:20];
            r = ($urandom_range(0, 19) == 0);
            pc = pc + 32'd4;
            cyc(r, ins, pc, pc + 32'd4, 1'($urandom), wa, $urandom);
            total++;
            if (gotv !== expv) begin
                bad++;
                $display("FAIL rand i=%0d ins=%h got=%h want=%h",
                         i, ins, gotv, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_release();
        test_bypass();
        test_load_store();
        test_jal();
        test_x0();
        test_nop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
